// File: rtl/mem_access_unit_if.sv
// Bus between the memory access unit (master) and the external data memory (slave).
interface mem_access_unit_if #(
   parameter int unsigned addr_width = 32,
   parameter int unsigned mem_width  = 32
);
   logic                  bus_req;
   logic                  bus_we;
   logic [addr_width-1:0] bus_addr;
   logic [mem_width-1:0]  bus_wdata;
   logic                  bus_ack;
   logic [mem_width-1:0]  bus_rdata;

   modport master (
      output bus_req, bus_we, bus_addr, bus_wdata,
      input  bus_ack, bus_rdata
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_wdata,
      output bus_ack, bus_rdata
   );
endinterface

// File: rtl/mem_access_unit.sv
// Multi-cycle data-memory access stage: turns single-cycle load/store requests
// into a req/ack bus transaction and stalls the datapath while it is in flight.
module mem_access_unit #(
   parameter int unsigned addr_width     = 32,
   parameter int unsigned mem_width      = 32,
   parameter int unsigned timeout_cycles = 16,
   parameter int unsigned to_width       = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mem_rd,
   input  logic                  mem_wr,
   input  logic [addr_width-1:0] addr,
   input  logic [mem_width-1:0]  wrd_mem,
   output logic [mem_width-1:0]  rdd_mem,
   output logic                  stall,
   mem_access_unit_if.master     bus,
   output logic                  misalign,
   output logic                  timeout_err
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t              state;
   logic [to_width-1:0] cnt;
   logic                req;
   logic                aligned;
   logic                last_cycle;

   assign req        = mem_rd | mem_wr;
   assign aligned    = (addr[1:0] == 2'b00);
   assign last_cycle = (cnt == to_width'(timeout_cycles - 1));

   // Held low during reset so the datapath is never frozen by a dead transaction.
   assign stall = !rst && (((state == IDLE) && req && aligned) || (state == ACCESS));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         cnt           <= '0;
         rdd_mem       <= '0;
         bus.bus_req   <= 1'b0;
         bus.bus_we    <= 1'b0;
         bus.bus_addr  <= '0;
         bus.bus_wdata <= '0;
         misalign      <= 1'b0;
         timeout_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  if (aligned) begin
                     bus.bus_addr <= addr;
                     bus.bus_we   <= mem_wr;
                     if (mem_wr) begin
                        bus.bus_wdata <= wrd_mem;
                     end
                     bus.bus_req <= 1'b1;
                     cnt         <= '0;
                     state       <= ACCESS;
                  end else begin
                     misalign <= 1'b1;
                  end
               end
            end
            ACCESS: begin
               cnt <= cnt + to_width'(1);
               // An ack in the final allowed cycle takes priority over the timeout.
               if (bus.bus_ack) begin
                  if (!bus.bus_we) begin
                     rdd_mem <= bus.bus_rdata;
                  end
                  bus.bus_req <= 1'b0;
                  bus.bus_we  <= 1'b0;
                  state       <= DONE;
               end else if (last_cycle) begin
                  // Stores leave the load-data register untouched even when abandoned.
                  if (!bus.bus_we) begin
                     rdd_mem <= '0;
                  end
                  timeout_err <= 1'b1;
                  bus.bus_req <= 1'b0;
                  bus.bus_we  <= 1'b0;
                  state       <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: transaction-level model of each
// instruction (cycle counts, data, sticky flags) driven with random stimulus.
module tb_mem_access_unit;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int TO = 16;

   logic          clk;
   logic          rst;
   logic          mem_rd;
   logic          mem_wr;
   logic [AW-1:0] addr;
   logic [DW-1:0] wrd_mem;
   logic [DW-1:0] rdd_mem;
   logic          stall;
   logic          misalign;
   logic          timeout_err;

   mem_access_unit_if #(.addr_width(AW), .mem_width(DW)) bus_if ();

   mem_access_unit #(
      .addr_width(AW), .mem_width(DW), .timeout_cycles(TO), .to_width(5)
   ) dut (
      .clk(clk), .rst(rst), .mem_rd(mem_rd), .mem_wr(mem_wr), .addr(addr),
      .wrd_mem(wrd_mem), .rdd_mem(rdd_mem), .stall(stall), .bus(bus_if),
      .misalign(misalign), .timeout_err(timeout_err)
   );

   int tests = 0;
   int fails = 0;

   // Reference model state
   logic [DW-1:0] m_rdd;
   logic [DW-1:0] m_wdata;
   logic          m_misalign;
   logic          m_timeout;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_rdd = '0; m_wdata = '0; m_misalign = 1'b0; m_timeout = 1'b0;
   endtask

   // One cycle with no request; stray acks must be ignored.
   task automatic idle_cycle(input string name);
      mem_rd = 1'b0; mem_wr = 1'b0;
      addr = $urandom; wrd_mem = $urandom;
      bus_if.bus_ack = 1'($urandom % 2); bus_if.bus_rdata = $urandom;
      @(negedge clk);
      tests++;
      if (stall !== 1'b0 || bus_if.bus_req !== 1'b0) begin
         fails++;
         $display("FAIL %s idle: stall=%b bus_req=%b, required 0/0", name, stall, bus_if.bus_req);
      end
      tests++;
      if (rdd_mem !== m_rdd || misalign !== m_misalign || timeout_err !== m_timeout) begin
         fails++;
         $display("FAIL %s idle state: rdd=%h mis=%b to=%b, required %h/%b/%b",
                  name, rdd_mem, misalign, timeout_err, m_rdd, m_misalign, m_timeout);
      end
      step();
   endtask

   // One complete instruction. ack_at: ACCESS cycle (1-based) carrying the ack, 0 = never.
   task automatic do_access(input logic rd, input logic wr, input logic [AW-1:0] a,
                            input logic [DW-1:0] wd, input int ack_at,
                            input logic [DW-1:0] rdata, input string name);
      int n_acc;
      bit acked;
      int stall_cnt;
      int req_cnt;
      stall_cnt = 0; req_cnt = 0;
      mem_rd = rd; mem_wr = wr; addr = a; wrd_mem = wd;
      bus_if.bus_ack = 1'b0; bus_if.bus_rdata = $urandom;
      if (a[1:0] != 2'b00) begin
         @(negedge clk);
         tests++;
         if (stall !== 1'b0 || bus_if.bus_req !== 1'b0) begin
            fails++;
            $display("FAIL %s misaligned: stall=%b bus_req=%b, required 0/0", name, stall, bus_if.bus_req);
         end
         step();
         m_misalign = 1'b1;
         tests++;
         if (misalign !== 1'b1 || bus_if.bus_req !== 1'b0 || rdd_mem !== m_rdd) begin
            fails++;
            $display("FAIL %s misaligned after: mis=%b bus_req=%b rdd=%h, required 1/0/%h",
                     name, misalign, bus_if.bus_req, rdd_mem, m_rdd);
         end
         return;
      end
      acked = (ack_at >= 1 && ack_at <= TO);
      n_acc = acked ? ack_at : TO;
      if (wr) m_wdata = wd;
      @(negedge clk);
      if (stall === 1'b1) stall_cnt++;
      tests++;
      if (stall !== 1'b1 || bus_if.bus_req !== 1'b0) begin
         fails++;
         $display("FAIL %s launch: stall=%b bus_req=%b, required 1/0", name, stall, bus_if.bus_req);
      end
      step();
      for (int k = 1; k <= n_acc; k++) begin
         bus_if.bus_ack = (acked && k == ack_at);
         bus_if.bus_rdata = bus_if.bus_ack ? rdata : DW'($urandom);
         @(negedge clk);
         if (stall === 1'b1) stall_cnt++;
         if (bus_if.bus_req === 1'b1) req_cnt++;
         tests++;
         if (bus_if.bus_addr !== a || bus_if.bus_we !== wr || bus_if.bus_wdata !== m_wdata) begin
            fails++;
            $display("FAIL %s access cyc %0d: addr=%h we=%b wdata=%h, required %h/%b/%h",
                     name, k, bus_if.bus_addr, bus_if.bus_we, bus_if.bus_wdata, a, wr, m_wdata);
         end
         step();
      end
      if (acked && !wr) m_rdd = rdata;
      if (!acked) begin
         m_timeout = 1'b1;
         if (!wr) m_rdd = '0;
      end
      bus_if.bus_ack = 1'($urandom % 2);
      bus_if.bus_rdata = $urandom;
      @(negedge clk);
      tests++;
      if (stall !== 1'b0 || bus_if.bus_req !== 1'b0 || bus_if.bus_we !== 1'b0) begin
         fails++;
         $display("FAIL %s done: stall=%b bus_req=%b we=%b, required 0/0/0",
                  name, stall, bus_if.bus_req, bus_if.bus_we);
      end
      tests++;
      if (rdd_mem !== m_rdd || timeout_err !== m_timeout || misalign !== m_misalign) begin
         fails++;
         $display("FAIL %s done data: rdd=%h to=%b mis=%b, required %h/%b/%b",
                  name, rdd_mem, timeout_err, misalign, m_rdd, m_timeout, m_misalign);
      end
      tests++;
      if (stall_cnt != n_acc + 1 || req_cnt != n_acc) begin
         fails++;
         $display("FAIL %s latency: stall cycles=%0d req cycles=%0d, required %0d/%0d",
                  name, stall_cnt, req_cnt, n_acc + 1, n_acc);
      end
      step();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus_if.bus_ack = 1'b0; bus_if.bus_rdata = '0;
      model_reset();
      for (int i = 0; i < 4; i++) begin
         mem_rd = 1'b1; mem_wr = 1'($urandom % 2);
         addr = {$urandom, 2'b00} ; wrd_mem = $urandom;
         bus_if.bus_ack = 1'($urandom % 2); bus_if.bus_rdata = $urandom;
         @(negedge clk);
         tests++;
         if ({stall, bus_if.bus_req, bus_if.bus_we, bus_if.bus_addr, bus_if.bus_wdata,
              rdd_mem, misalign, timeout_err} !== '0) begin
            fails++;
            $display("FAIL reset outputs: stall=%b req=%b we=%b addr=%h wdata=%h rdd=%h mis=%b to=%b, required all 0",
                     stall, bus_if.bus_req, bus_if.bus_we, bus_if.bus_addr, bus_if.bus_wdata,
                     rdd_mem, misalign, timeout_err);
         end
      end
      @(posedge clk);
      #1;
      mem_rd = 1'b0; mem_wr = 1'b0;
      rst = 1'b0;
      for (int i = 0; i < 5; i++) idle_cycle("reset_release");
   endtask

   task automatic test_load();
      do_access(1'b1, 1'b0, 32'h10, 32'h0, 1, 32'hDEADBEEF, "load");
      idle_cycle("load_after");
   endtask

   task automatic test_store();
      do_access(1'b0, 1'b1, 32'h20, 32'h12345678, 4, 32'hA5A5A5A5, "store");
      idle_cycle("store_after");
   endtask

   task automatic test_misalign();
      do_access(1'b1, 1'b0, 32'h13, 32'h0, 1, 32'h0, "misalign");
      idle_cycle("misalign_after");
      do_access(1'b1, 1'b0, 32'h40, 32'h0, 2, 32'hCAFEF00D, "misalign_then_aligned");
      idle_cycle("misalign_sticky");
   endtask

   task automatic test_timeout();
      do_access(1'b1, 1'b0, 32'h100, 32'h0, TO, 32'h0BADCAFE, "ack_last_cycle");
      idle_cycle("ack_last_after");
      do_access(1'b1, 1'b0, 32'h104, 32'h0, 0, 32'h0, "timeout");
      idle_cycle("timeout_after");
   endtask

   task automatic test_reset_mid_access();
      mem_rd = 1'b1; mem_wr = 1'b0; addr = 32'h80; wrd_mem = $urandom;
      bus_if.bus_ack = 1'b0;
      step();
      step();
      @(negedge clk);
      tests++;
      if (bus_if.bus_req !== 1'b1) begin
         fails++;
         $display("FAIL midreset pre: bus_req=%b, required 1", bus_if.bus_req);
      end
      #1 rst = 1'b1;
      #1;
      model_reset();
      tests++;
      if ({stall, bus_if.bus_req, bus_if.bus_we, bus_if.bus_addr, bus_if.bus_wdata,
           rdd_mem, misalign, timeout_err} !== '0) begin
         fails++;
         $display("FAIL midreset async: stall=%b req=%b we=%b addr=%h rdd=%h mis=%b to=%b, required all 0",
                  stall, bus_if.bus_req, bus_if.bus_we, bus_if.bus_addr, rdd_mem, misalign, timeout_err);
      end
      @(posedge clk);
      #1;
      mem_rd = 1'b0;
      rst = 1'b0;
      idle_cycle("midreset_release");
   endtask

   task automatic test_back_to_back();
      do_access(1'b1, 1'b0, 32'h200, 32'h0, 1, 32'h11223344, "b2b_load");
      do_access(1'b0, 1'b1, 32'h204, 32'h55667788, 2, 32'h0, "b2b_store");
      do_access(1'b1, 1'b1, 32'h208, 32'h99AABBCC, 1, 32'hFFFFFFFF, "b2b_both");
      idle_cycle("b2b_after");
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         logic rd, wr;
         logic [AW-1:0] a;
         int kind, ack_at;
         kind = int'($urandom % 3);
         rd = (kind != 1);
         wr = (kind != 0);
         a = $urandom;
         if ($urandom % 4 != 0) a[1:0] = 2'b00;
         if (!wr && ($urandom % 8 == 0)) ack_at = 0;
         else ack_at = 1 + int'($urandom % 5);
         do_access(rd, wr, a, DW'($urandom), ack_at, DW'($urandom), "random");
         if ($urandom % 2 == 1) idle_cycle("random_gap");
      end
   endtask

   initial begin
      rst = 1'b1; mem_rd = 1'b0; mem_wr = 1'b0; addr = '0; wrd_mem = '0;
      bus_if.bus_ack = 1'b0; bus_if.bus_rdata = '0;
      model_reset();
      test_reset();
      test_load();
      test_store();
      test_misalign();
      test_timeout();
      test_reset_mid_access();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Multi-cycle data-memory access stage. It sits directly downstream of the MIPS datapath's ALU-result and store-data outputs, and upstream of that datapath's load-data input.
It converts single-cycle load/store requests into a req/ack bus transaction toward an external data memory. While a transaction is outstanding it asserts `stall`, which freezes the PC and register-file write. It returns load data on `rdd_mem`.

Parameters:
- `addr_width`, 32, width of the byte address (the ALU result).
- `mem_width`, 32, data word width.
- `timeout_cycles`, 16, maximum number of ACCESS-state cycles allowed before the access is abandoned.
- `to_width`, 5, width of the timeout counter; must hold `timeout_cycles`.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `mem_rd`  in  1  load request from control, level-held for the whole instruction.
- `mem_wr`  in  1  store request from control, level-held for the whole instruction.
- `addr`  in  `addr_width`  byte address (datapath `alu_res`).
- `wrd_mem`  in  `mem_width`  store data from the datapath.
- `rdd_mem`  out  `mem_width`  load data to the datapath; registered.
- `stall`  out  1  freezes the datapath; combinational from state and request.
- `bus_req`  out  1  bus request; registered.
- `bus_we`  out  1  bus write enable; registered.
- `bus_addr`  out  `addr_width`  bus address; registered.
- `bus_wdata`  out  `mem_width`  bus write data; registered.
- `bus_ack`  in  1  single-cycle completion strobe from memory.
- `bus_rdata`  in  `mem_width`  memory read data; valid when `bus_ack`=1.
- `misalign`  out  1  sticky flag: misaligned access seen.
- `timeout_err`  out  1  sticky flag: bus access timed out.

Behaviour:
- **Reset:** `rst`=1 forces, asynchronously, state=IDLE, counter=0, and every output to 0. This includes `rdd_mem`, `bus_*`, `misalign` and `timeout_err`. A reset during ACCESS drops `bus_req` immediately and does not complete the access.
- **States:** IDLE, ACCESS, DONE.
- **Request classes:**
  - `req` = `mem_rd` | `mem_wr`.
  - `wr` = `mem_wr`; a store wins if both are high.
  - `aligned` = (`addr[1:0]` == 0).
- **IDLE:**
  - If `req` & `aligned`: `stall`=1. On the clock edge latch `bus_addr`=`addr`, `bus_we`=`wr`, `bus_wdata`=`wrd_mem` (stores only; otherwise hold), set `bus_req`=1, clear the counter, and go to ACCESS.
  - If `req` & !`aligned`: no bus transaction and `stall`=0. Set `misalign`=1 and hold `rdd_mem`; the instruction completes in this cycle.
  - If !`req`: `stall`=0, stay in IDLE.
- **ACCESS:**
  - `stall`=1.
  - `bus_addr`, `bus_we`, `bus_wdata` and `bus_req` are held stable.
  - The counter increments each cycle.
- **ACCESS exit on ack:** if `bus_ack`=1, then on the clock edge:
  - if `bus_we`=0, capture `rdd_mem`=`bus_rdata`;
  - clear `bus_req` and `bus_we`;
  - go to DONE.
- **ACCESS exit on timeout:** if no ack in the `timeout_cycles`-th ACCESS cycle, then on the clock edge set `rdd_mem`=0, `timeout_err`=1, clear `bus_req` and `bus_we`, and go to DONE.
  - If ack arrives in that same cycle, the ack wins and `timeout_err` is not set.
- **DONE:**
  - `stall`=0, and the datapath completes the instruction at this edge using `rdd_mem`.
  - The still-asserted `req` is ignored.
  - Return to IDLE unconditionally.
- **Stray acks:** `bus_ack` while `bus_req`=0 is ignored.
- **Latency:** with ack in the first ACCESS cycle, `stall` is high for 2 cycles (IDLE, ACCESS) and the instruction takes 3 cycles. Each ack wait cycle adds 1 cycle.
- **Back-to-back accesses:** a new request in the IDLE cycle after DONE launches immediately; there are no idle gap cycles beyond DONE.
- **Sticky flags:** `misalign` and `timeout_err` are cleared only by `rst`.
- **Store data:** `rdd_mem` is never modified by stores.

Test Plan:
1. Assert `rst` with random inputs → all outputs 0. Release `rst` with `req`=0 → `stall`=0 and `bus_req`=0 indefinitely.
2. Load: `addr`=0x10, `bus_ack` in the 1st ACCESS cycle with `bus_rdata`=0xDEADBEEF → `bus_req` high for exactly 1 cycle with `bus_addr`=0x10 and `bus_we`=0. `stall` is high for 2 cycles. `rdd_mem`=0xDEADBEEF in DONE.
3. Store: `addr`=0x20, `wrd_mem`=0x12345678, ack after 3 wait cycles → `bus_we`=1 and `bus_wdata`=0x12345678 held for 4 cycles. `stall` is high for 5 cycles. `rdd_mem` is unchanged.
4. Load with `addr`=0x13 → no `bus_req`, `stall`=0, `misalign`=1, and `misalign` stays 1 after a following aligned access.
5. Load with no ack and `timeout_cycles`=16 → `bus_req` high for 16 cycles, then DONE with `rdd_mem`=0 and `timeout_err`=1. Repeat with ack in cycle 16 → `timeout_err` stays 0.
6. Reset mid-ACCESS (cycle 2), then back-to-back load followed by store → `bus_req` falls asynchronously with `rst` and all outputs go to 0. After release, the load and store launch in consecutive IDLE cycles following each DONE.
